stream_demux_1_4: RTL and testbench
===================================

STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data width of the input word and of each output lane.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  the input word is offered.
REQ-005 SHALL have port in_ready  output  1  the block accepts the offered word this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  the input word.
REQ-007 SHALL have port in_sel  input  2  the destination lane index; ignored when DEMUX_RR_EN is defined.
REQ-008 SHALL have port out_valid  output  4  per-lane valid; bit i belongs to lane i.
REQ-009 SHALL have port out_ready  input  4  per-lane downstream ready; bit i belongs to lane i.
REQ-010 SHALL have ports d0, d1, d2, d3  output  WIDTH  lane 0..3 data, each driven from its holding register.

Function
REQ-011 SHALL provide one holding register (data plus full flag) per lane; out_valid[i] SHALL equal full[i].
REQ-012 SHALL define the destination lane dst as in_sel, or as the round-robin pointer when DEMUX_RR_EN is defined.
REQ-013 SHALL drive in_ready = ~full[dst] | out_ready[dst], combinationally; in_ready SHALL NOT depend on in_valid.
REQ-014 SHALL accept the word (acc) in any cycle where in_valid & in_ready.
REQ-015 SHALL, on acc, load in_data into the lane-dst register and set full[dst] on the next edge; latency from accept to out_valid is 1 cycle.
REQ-016 SHALL, for each lane, treat out_valid[i] & out_ready[i] as a drain, and clear full[i] on the next edge unless the same lane is loaded that cycle.
REQ-017 SHALL, on a simultaneous drain and load of the same lane, replace the data with the new word and keep full set; there is no bubble.
REQ-018 SHALL allow a drain of any lane concurrently with a load of a different lane; lanes are independent.
REQ-019 SHALL hold d[i] stable while full[i] & ~out_ready[i]; d[i] SHALL retain its last value after a drain.
REQ-020 SHALL never drop, duplicate or reorder words within a lane.
REQ-021 SHALL stall the input when dst is full and not draining, without affecting other lanes.

Reset
REQ-022 SHALL, while rst=1, clear out_valid to 4'b0000, clear d0..d3 to 0, and clear the round-robin pointer to 0, independent of clk.
REQ-023 SHALL, while rst=1, drive in_ready=0.
REQ-024 SHALL discard words held at reset assertion mid-operation; the first accept after rst deasserts SHALL go to lane in_sel, or to lane 0 in round-robin mode.

Configuration
REQ-025 SHALL support macro DEMUX_RR_EN.
REQ-026 SHALL, when DEMUX_RR_EN is defined, use a 2-bit pointer as dst, ignore in_sel, and advance the pointer by 1 only on acc, wrapping 3->0.
REQ-027 SHALL, when DEMUX_RR_EN is defined and the pointed lane is full and not draining, stall the input rather than skip to a free lane.
REQ-028 SHALL, without DEMUX_RR_EN, contain no pointer logic and route each word by in_sel.

Verification
REQ-029 SHALL cover directed routing, no macro: with out_ready=4'b1111, send 4'hA sel=2 -> next cycle out_valid=4'b0100, d2=4'hA, then out_valid=0.
REQ-030 SHALL cover backpressure: with out_ready[1]=0, send 4'h3 then 4'h5 to sel=1 -> in_ready=0 on the second word until out_ready[1]=1, d1=4'h3 first then 4'h5, and no loss.
REQ-031 SHALL cover same-lane drain plus load: with lane 0 full of 4'h7, out_ready[0]=1, send 4'h9 sel=0 -> in_ready=1, out_valid[0] stays 1, and d0 becomes 4'h9 next cycle.
REQ-032 SHALL cover parallel lanes: fill lanes 0 and 3, and drain lane 3 while loading lane 1 -> out_valid=4'b0011 after the edge.
REQ-033 SHALL cover round robin, DEMUX_RR_EN defined: send 5 words 1..5 with all ready -> they appear on lanes 0,1,2,3,0 and the pointer wraps.
REQ-034 SHALL cover reset mid-operation: with lanes 0 and 2 full, assert rst between edges -> out_valid=0 immediately, in_ready=0, and after release the pointer is 0.

Source files
------------

// File: rtl/stream_demux_1_4.sv
// rtl/stream_demux_1_4.sv - 1-to-4 stream demux with one holding register per lane
// Optional macro DEMUX_RR_EN: route by a round-robin pointer instead of in_sel.
module stream_demux_1_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3
);

  logic [3:0]       full;
  logic [WIDTH-1:0] data [4];
  logic [1:0]       dst;
  logic             acc;
  logic [3:0]       load;
  logic [3:0]       drain;

`ifdef DEMUX_RR_EN
  logic [1:0] ptr;
  logic       unused_sel;

  assign unused_sel = ^in_sel;
  assign dst        = ptr;

  // Pointer only moves on an accepted word, so a full lane stalls rather than skips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (acc) begin
      ptr <= ptr + 2'd1;
    end
  end
`else
  assign dst = in_sel;
`endif

  // A lane can take a word when empty or when its current word leaves this cycle.
  assign in_ready = ~rst & (~full[dst] | out_ready[dst]);
  assign acc      = in_valid & in_ready;
  assign drain    = full & out_ready;

  always_comb begin
    load = 4'b0000;
    if (acc) begin
      load[dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data[i] <= in_data;
          full[i] <= 1'b1;
        end else if (drain[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = full;
  assign d0        = data[0];
  assign d1        = data[1];
  assign d2        = data[2];
  assign d3        = data[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb/tb_stream_demux_1_4.sv - self-checking bench for stream_demux_1_4 against a lane-occupancy model
module tb_stream_demux_1_4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] d0, d1, d2, d3;

  int checks = 0;
  int errors = 0;

  // Reference model: what each lane currently holds, and how many words were accepted.
  logic [3:0] mfull;
  logic [3:0] mdata [4];
  int         acc_count;

  stream_demux_1_4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dlane(input int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  task automatic model_reset();
    mfull = 4'b0000;
    for (int i = 0; i < 4; i++) mdata[i] = 4'h0;
    acc_count = 0;
  endtask

  // One cycle: drive at negedge, compare before the rising edge, advance the model after it.
  task automatic step(input logic v, input logic [1:0] s, input logic [3:0] dat, input logic [3:0] rdy);
    int   lane;
    logic exp_rdy;
    in_valid  = v;
    in_sel    = s;
    in_data   = dat;
    out_ready = rdy;
    #1;
`ifdef DEMUX_RR_EN
    lane = acc_count % 4;
`else
    lane = int'(s);
`endif
    exp_rdy = !mfull[lane] || rdy[lane];
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {28'b0, out_valid}, {28'b0, mfull});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d", i), {28'b0, dlane(i)}, {28'b0, mdata[i]});
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (mfull[i] && rdy[i]) mfull[i] = 1'b0;
    end
    if (v && exp_rdy) begin
      mfull[lane] = 1'b1;
      mdata[lane] = dat;
      acc_count++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 4'h0;
    out_ready = 4'b0000;
    model_reset();

    #3;
    chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_d0", {28'b0, d0}, 32'h0);
    chk("rst_d3", {28'b0, d3}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

`ifdef DEMUX_RR_EN
    // Five words with everyone ready land on lanes 0,1,2,3 and wrap back to 0.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 2'd3, 4'(k), 4'b1111);
      chk($sformatf("rr_lane_w%0d", k), {28'b0, out_valid}, 32'(1 << ((k - 1) % 4)));
      chk($sformatf("rr_data_w%0d", k), {28'b0, dlane((k - 1) % 4)}, 32'(k));
    end
    step(1'b0, 2'd0, 4'h0, 4'b1111);
`else
    step(1'b1, 2'd2, 4'hA, 4'b1111);
    chk("route_valid", {28'b0, out_valid}, 32'h4);
    chk("route_d2", {28'b0, d2}, 32'hA);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
    chk("route_drained", {28'b0, out_valid}, 32'h0);

    // Backpressure on lane 1: the second word waits until the first leaves.
    step(1'b1, 2'd1, 4'h3, 4'b1101);
    chk("bp_first_d1", {28'b0, d1}, 32'h3);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h5; out_ready = 4'b1101;
      #1;
      chk("bp_stall", {31'b0, in_ready}, 32'h0);
      step(1'b1, 2'd1, 4'h5, 4'b1101);
    end
    chk("bp_hold_d1", {28'b0, d1}, 32'h3);
    step(1'b1, 2'd1, 4'h5, 4'b1111);
    chk("bp_second_d1", {28'b0, d1}, 32'h5);
    chk("bp_second_valid", {28'b0, out_valid}, 32'h2);
    step(1'b0, 2'd0, 4'h0, 4'b1111);

    // Same-lane drain and load: no bubble.
    step(1'b1, 2'd0, 4'h7, 4'b0000);
    step(1'b1, 2'd0, 4'h9, 4'b0001);
    chk("swap_valid0", {31'b0, out_valid[0]}, 32'h1);
    chk("swap_d0", {28'b0, d0}, 32'h9);
    step(1'b0, 2'd0, 4'h0, 4'b1111);

    // Parallel lanes: drain 3 while loading 1, lane 0 keeps its word.
    step(1'b1, 2'd0, 4'h1, 4'b0000);
    step(1'b1, 2'd3, 4'h4, 4'b0000);
    step(1'b1, 2'd1, 4'h2, 4'b1000);
    chk("parallel_valid", {28'b0, out_valid}, 32'h3);
    step(1'b0, 2'd0, 4'h0, 4'b1111);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    step(1'b0, 2'd0, 4'h0, 4'b1111);

    // Reset mid-operation with lanes 0 and 2 holding words.
`ifdef DEMUX_RR_EN
    while (acc_count % 4 != 0) step(1'b1, 2'd0, 4'hF, 4'b1111);
    step(1'b1, 2'd0, 4'hB, 4'b0000);
    step(1'b1, 2'd0, 4'hE, 4'b0000);
    step(1'b1, 2'd0, 4'hC, 4'b0000);
    chk("pre_rst_valid", {28'b0, out_valid}, 32'h7);
`else
    step(1'b1, 2'd0, 4'hB, 4'b0000);
    step(1'b1, 2'd2, 4'hC, 4'b0000);
    chk("pre_rst_valid", {28'b0, out_valid}, 32'h5);
`endif
    in_valid = 1'b1; in_sel = 2'd3; in_data = 4'h6; out_ready = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {28'b0, out_valid}, 32'h0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'h0);
    chk("mid_rst_d2", {28'b0, d2}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'd3, 4'h6, 4'b0000);
`ifdef DEMUX_RR_EN
    chk("post_rst_lane", {28'b0, out_valid}, 32'h1);
    chk("post_rst_d0", {28'b0, d0}, 32'h6);
`else
    chk("post_rst_lane", {28'b0, out_valid}, 32'h8);
    chk("post_rst_d3", {28'b0, d3}, 32'h6);
`endif
    step(1'b0, 2'd0, 4'h0, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
